gba_sound_dma_feeder: RTL and testbench

GBA_SOUND_DMA_FEEDER -- requirements
Module: gba_sound_dma_feeder

---
 rtl/gba_sound_dma_feeder.sv | 146 ++++++++++++++
 tb/tb_gba_sound_dma_feeder.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gba_sound_dma_feeder.sv
// gba_sound_dma_feeder
//
// Sound-FIFO DMA channel. Each refill request from the sound FIFO moves one
// block of exactly four 32-bit words. Each word is read from the source pointer
// and then written to the fixed FIFO register address.
//
// Ports
//   clk, reset          : system clock; synchronous active-high reset
//   enable              : channel enable; a 0->1 edge reloads the source pointer
//   src_addr, src_ctrl  : source start address and step mode
//                         (00 inc, 01 dec, 10 fixed, 11 inc)
//   irq_enable          : request a one-cycle irq at the end of each block
//   dma_req             : one-cycle refill pulse from the sound FIFO
//   rd_req/rd_addr      : source read request and address, held until rd_ack
//   rd_ack/rd_data      : read-complete pulse and its data
//   wr_req/wr_addr/     : FIFO write request, held until wr_ack;
//   wr_data/wr_be       : the address is FIFO_ADDR and all four bytes are enabled
//   wr_ack              : write-complete pulse
//   busy                : high whenever a block is in flight
//   irq                 : end-of-block interrupt pulse

module gba_sound_dma_feeder #(
  parameter logic [31:0] FIFO_ADDR = 32'h040000A0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [27:0] src_addr,
  input  logic [1:0]  src_ctrl,
  input  logic        irq_enable,
  input  logic        dma_req,
  output logic        rd_req,
  output logic [27:0] rd_addr,
  input  logic        rd_ack,
  input  logic [31:0] rd_data,
  output logic        wr_req,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_be,
  input  logic        wr_ack,
  output logic        busy,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state;
  logic        enable_q;
  logic        enable_rise;
  logic        pending;
  logic [1:0]  wcnt;
  logic [27:0] ptr;
  logic [27:0] ptr_next;

  assign enable_rise = enable & ~enable_q;
  assign rd_addr     = ptr;
  assign wr_addr     = FIFO_ADDR;
  assign wr_be       = 4'hF;
  assign busy        = (state != IDLE);

  // Next source pointer after a completed read. Mode 11 behaves like increment.
  // The 28-bit width gives modulo-2^28 wrap for free.
  always_comb begin
    ptr_next = ptr + 28'd4;
    case (src_ctrl)
      2'b01:   ptr_next = ptr - 28'd4;
      2'b10:   ptr_next = ptr;
      default: ptr_next = ptr + 28'd4;
    endcase
  end

  // Block sequencer. Refill requests collapse into a single pending flag.
  // Leaving IDLE consumes that flag, so a dma_req in the same cycle is merged.
  // When enable is low at the moment a handshake completes, the block is
  // abandoned: the FSM returns to IDLE, no irq is raised, and pending is dropped.
  // An enable rising edge reloads the pointer and takes priority over the step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      enable_q <= 1'b0;
      pending  <= 1'b0;
      wcnt     <= 2'd0;
      ptr      <= 28'd0;
      wr_data  <= 32'd0;
      rd_req   <= 1'b0;
      wr_req   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      enable_q <= enable;
      irq      <= 1'b0;
      if (dma_req && enable) begin
        pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (pending && enable) begin
            state   <= READ;
            rd_req  <= 1'b1;
            pending <= 1'b0;
            wcnt    <= 2'd0;
          end
        end
        READ: begin
          if (rd_ack) begin
            wr_data <= rd_data;
            ptr     <= ptr_next;
            rd_req  <= 1'b0;
            if (enable) begin
              state  <= WRITE;
              wr_req <= 1'b1;
            end else begin
              state   <= IDLE;
              pending <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (wr_ack) begin
            wr_req <= 1'b0;
            wcnt   <= wcnt + 2'd1;
            if (!enable) begin
              state   <= IDLE;
              pending <= 1'b0;
            end else if (wcnt != 2'd3) begin
              state  <= READ;
              rd_req <= 1'b1;
            end else begin
              state <= DONE;
              irq   <= irq_enable;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (enable_rise) begin
        ptr <= {src_addr[27:2], 2'b00};
      end
    end
  end

endmodule

// File: tb/tb_gba_sound_dma_feeder.sv
// tb_gba_sound_dma_feeder
//
// Self-checking bench for gba_sound_dma_feeder. A memory/FIFO responder
// acknowledges requests after random delays and logs every read address and
// every written word. The main sequence compares those logs with addresses
// derived from the step rules (base + k*step, modulo 2^28).

module tb_gba_sound_dma_feeder;

  localparam logic [31:0] EXP_FIFO = 32'h040000A0;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [27:0] src_addr;
  logic [1:0]  src_ctrl;
  logic        irq_enable;
  logic        dma_req;
  logic        rd_req;
  logic [27:0] rd_addr;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        wr_ack;
  logic        busy;
  logic        irq;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [27:0] rd_log[$];
  logic [31:0] wr_log[$];
  int irq_cnt;
  int excl_err;
  int irq_wide;
  int attr_err;

  int   max_delay    = 0;
  int   hold_index   = -1;
  int   spurious_cnt = 0;
  logic resp_on      = 1'b1;

  typedef struct {
    string            name;
    logic [27:0]      src;
    logic [1:0]       ctrl;
    logic             irq_en;
    logic [3:0][27:0] exp_addr;
    int               exp_irq;
    logic [27:0]      exp_next;
  } vec_t;

  vec_t vecs[5];

  gba_sound_dma_feeder dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .src_addr   (src_addr),
    .src_ctrl   (src_ctrl),
    .irq_enable (irq_enable),
    .dma_req    (dma_req),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_ack     (rd_ack),
    .rd_data    (rd_data),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_be      (wr_be),
    .wr_ack     (wr_ack),
    .busy       (busy),
    .irq        (irq)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents seen by the channel: a fixed scramble of the word address.
  function automatic logic [31:0] data_of(input logic [27:0] a);
    return {a[3:0], a} ^ 32'hC3A5_0F1E;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic pulse_dma();
    @(negedge clk);
    dma_req = 1'b1;
    @(negedge clk);
    dma_req = 1'b0;
  endtask

  // Wait until the channel has been idle for three consecutive cycles.
  task automatic wait_idle(input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < budget) begin
      @(negedge clk);
      n++;
      if (!busy) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) checkOutput("idle_timeout", 64'd0, 64'd1);
  endtask

  // Set up one table vector: reload the pointer with a fresh enable edge, then run one block.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    enable     = 1'b0;
    src_addr   = v.src;
    src_ctrl   = v.ctrl;
    irq_enable = v.irq_en;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    pulse_dma();
    wait_idle(400);
  endtask

  // Responder and monitor. It acknowledges held requests on the falling edge
  // after a random delay, logs every transfer, and tallies protocol violations.
  initial begin : responder
    int   rd_wait;
    int   wr_wait;
    int   spurious_seen;
    logic irq_prev;
    rd_ack = 1'b0; wr_ack = 1'b0; rd_data = 32'd0;
    rd_wait = 0; wr_wait = 0; spurious_seen = 0; irq_prev = 1'b0;
    irq_cnt = 0; excl_err = 0; irq_wide = 0; attr_err = 0;
    forever begin
      @(negedge clk);
      rd_ack = 1'b0;
      wr_ack = 1'b0;
      if (rd_req && wr_req) excl_err++;
      if (irq) begin
        irq_cnt++;
        if (irq_prev) irq_wide++;
      end
      irq_prev = irq;
      if (spurious_cnt != spurious_seen) begin
        spurious_seen = spurious_cnt;
        rd_ack = 1'b1;
        wr_ack = 1'b1;
      end else if (resp_on) begin
        if (rd_req) begin
          if (rd_wait == 0) begin
            rd_ack  = 1'b1;
            rd_data = data_of(rd_addr);
            rd_log.push_back(rd_addr);
            rd_wait = $urandom_range(max_delay, 0);
          end else begin
            rd_wait--;
          end
        end
        if (wr_req && wr_log.size() != hold_index) begin
          if (wr_wait == 0) begin
            wr_ack = 1'b1;
            if (wr_addr !== EXP_FIFO || wr_be !== 4'hF) attr_err++;
            wr_log.push_back(wr_data);
            wr_wait = $urandom_range(max_delay, 0);
          end else begin
            wr_wait--;
          end
        end
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main test sequence.
  initial begin
    int rb, wb, ib, n, extra, blocks, step;
    logic [27:0] model_ptr, exp_a;
    logic [1:0]  cur_ctrl;

    vecs[0] = '{"basic",   28'h2000000, 2'b00, 1'b0,
                {28'h200000C, 28'h2000008, 28'h2000004, 28'h2000000}, 0, 28'h2000010};
    vecs[1] = '{"dec_irq", 28'h3000010, 2'b01, 1'b1,
                {28'h3000004, 28'h3000008, 28'h300000C, 28'h3000010}, 1, 28'h3000000};
    vecs[2] = '{"fixed",   28'h2000003, 2'b10, 1'b0,
                {28'h2000000, 28'h2000000, 28'h2000000, 28'h2000000}, 0, 28'h2000000};
    vecs[3] = '{"inc_wrap", 28'hFFFFFF8, 2'b11, 1'b1,
                {28'h0000004, 28'h0000000, 28'hFFFFFFC, 28'hFFFFFF8}, 1, 28'h0000008};
    vecs[4] = '{"dec_wrap", 28'h0000006, 2'b01, 1'b0,
                {28'hFFFFFF8, 28'hFFFFFFC, 28'h0000000, 28'h0000004}, 0, 28'hFFFFFF4};

    reset = 1'b1; enable = 1'b0; src_addr = 28'd0; src_ctrl = 2'b00;
    irq_enable = 1'b0; dma_req = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_rd_req",  rd_req,  0);
    checkOutput("rst_wr_req",  wr_req,  0);
    checkOutput("rst_busy",    busy,    0);
    checkOutput("rst_irq",     irq,     0);
    checkOutput("rst_wr_data", wr_data, 0);
    checkOutput("rst_rd_addr", rd_addr, 0);
    checkOutput("rst_wr_addr", wr_addr, EXP_FIFO);
    checkOutput("rst_wr_be",   wr_be,   4'hF);

    // Minimum latency: dma_req to the first rd_req, with a same-cycle ack.
    reset = 1'b0; src_addr = 28'h2000100; enable = 1'b1;
    @(negedge clk);
    max_delay = 0;
    rb = rd_log.size();
    @(negedge clk);
    dma_req = 1'b1;
    @(negedge clk);
    dma_req = 1'b0;
    checkOutput("lat_c1_rd_req", rd_req, 0);
    @(negedge clk);
    checkOutput("lat_c2_rd_req",  rd_req,  1);
    checkOutput("lat_c2_rd_addr", rd_addr, 28'h2000100);
    checkOutput("lat_c2_busy",    busy,    1);
    wait_idle(400);
    checkOutput("lat_nreads", rd_log.size() - rb, 4);

    // Table-driven single blocks, plus a follow-up block to observe the continued pointer.
    max_delay = 2;
    for (int v = 0; v < 5; v++) begin
      rb = rd_log.size(); wb = wr_log.size(); ib = irq_cnt;
      applyStimulus(vecs[v]);
      checkOutput({vecs[v].name, "_nreads"},  rd_log.size() - rb, 4);
      checkOutput({vecs[v].name, "_nwrites"}, wr_log.size() - wb, 4);
      for (int j = 0; j < 4; j++) begin
        if (rb + j < rd_log.size())
          checkOutput($sformatf("%s_addr%0d", vecs[v].name, j), rd_log[rb + j], vecs[v].exp_addr[j]);
        if (wb + j < wr_log.size())
          checkOutput($sformatf("%s_data%0d", vecs[v].name, j), wr_log[wb + j], data_of(vecs[v].exp_addr[j]));
      end
      checkOutput({vecs[v].name, "_irq"},  irq_cnt - ib, vecs[v].exp_irq);
      checkOutput({vecs[v].name, "_busy"}, busy, 0);
      rb = rd_log.size();
      pulse_dma();
      wait_idle(400);
      if (rb < rd_log.size())
        checkOutput({vecs[v].name, "_next"}, rd_log[rb], vecs[v].exp_next);
      else
        checkOutput({vecs[v].name, "_next_missing"}, 0, 1);
    end

    // Coalescing: two refills during block 1 add exactly one more block.
    applyStimulus('{"coal", 28'h2000000, 2'b00, 1'b0, 112'd0, 0, 28'd0});
    rb = rd_log.size(); wb = wr_log.size();
    pulse_dma();
    pulse_dma();
    pulse_dma();
    wait_idle(400);
    checkOutput("coal_nreads", rd_log.size() - rb, 8);
    for (int k = 0; k < 8; k++) begin
      exp_a = 28'h2000010 + 28'(4 * k);
      if (rb + k < rd_log.size()) checkOutput($sformatf("coal_addr%0d", k), rd_log[rb + k], exp_a);
      if (wb + k < wr_log.size()) checkOutput($sformatf("coal_data%0d", k), wr_log[wb + k], data_of(exp_a));
    end

    // A refill while disabled is ignored and does not survive the next enable edge.
    @(negedge clk);
    enable = 1'b0;
    pulse_dma();
    repeat (3) @(negedge clk);
    checkOutput("dis_req_busy", busy, 0);
    enable = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("dis_req_busy_after_en", busy, 0);

    // Disable during the write of word 2: that write completes, then nothing more.
    enable = 1'b0; src_addr = 28'h2000000; src_ctrl = 2'b00; irq_enable = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    max_delay = 1;
    rb = rd_log.size(); wb = wr_log.size(); ib = irq_cnt;
    hold_index = wr_log.size() + 1;
    pulse_dma();
    n = 0;
    @(negedge clk); #1;
    while (!(wr_req && wr_log.size() == hold_index) && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("abort_reached_write2", (wr_req && wr_log.size() == hold_index), 1);
    pulse_dma();
    @(negedge clk);
    enable = 1'b0;
    hold_index = -1;
    wait_idle(200);
    checkOutput("abort_nreads",  rd_log.size() - rb, 2);
    checkOutput("abort_nwrites", wr_log.size() - wb, 2);
    if (wb + 1 < wr_log.size()) checkOutput("abort_data1", wr_log[wb + 1], data_of(28'h2000004));
    checkOutput("abort_irq", irq_cnt - ib, 0);
    @(negedge clk);
    enable = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("abort_pending_cleared", busy, 0);
    checkOutput("abort_no_more_reads", rd_log.size() - rb, 2);

    // Reset while a read is outstanding, with enable held high throughout.
    resp_on = 1'b0; irq_enable = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    pulse_dma();
    n = 0;
    while (!rd_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rstmid_saw_rd_req", rd_req, 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_rd_req", rd_req, 0);
    checkOutput("rstmid_busy",   busy,   0);
    @(negedge clk);
    checkOutput("rstmid_still_quiet", rd_req | wr_req, 0);
    reset = 1'b0; src_addr = 28'h2000040; resp_on = 1'b1;
    @(negedge clk);
    rb = rd_log.size();
    pulse_dma();
    wait_idle(400);
    checkOutput("rstmid_nreads", rd_log.size() - rb, 4);
    if (rb < rd_log.size()) checkOutput("rstmid_reload_addr", rd_log[rb], 28'h2000040);

    // Acks with no matching request must change nothing.
    @(negedge clk);
    spurious_cnt++;
    repeat (3) @(negedge clk);
    checkOutput("spur_busy", busy, 0);
    checkOutput("spur_reqs", rd_req | wr_req, 0);
    rb = rd_log.size();
    pulse_dma();
    wait_idle(400);
    if (rb < rd_log.size()) checkOutput("spur_ptr_unchanged", rd_log[rb], 28'h2000050);
    else checkOutput("spur_no_reads", 0, 1);

    // Randomized blocks, checked against the arithmetic address model.
    model_ptr = 28'd0; cur_ctrl = 2'b00;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 0 || $urandom_range(2, 0) == 0) begin
        enable   = 1'b0;
        src_addr = 28'($urandom);
        cur_ctrl = 2'($urandom);
        src_ctrl = cur_ctrl;
        @(negedge clk);
        enable    = 1'b1;
        model_ptr = {src_addr[27:2], 2'b00};
      end
      irq_enable = 1'($urandom);
      max_delay  = $urandom_range(3, 0);
      extra      = $urandom_range(2, 0);
      blocks     = (extra > 0) ? 2 : 1;
      step       = (cur_ctrl == 2'b01) ? -4 : (cur_ctrl == 2'b10) ? 0 : 4;
      rb = rd_log.size(); wb = wr_log.size(); ib = irq_cnt;
      @(negedge clk);
      pulse_dma();
      for (int e = 0; e < extra; e++) pulse_dma();
      wait_idle(600);
      checkOutput($sformatf("rnd%0d_nreads", i),  rd_log.size() - rb, 4 * blocks);
      checkOutput($sformatf("rnd%0d_nwrites", i), wr_log.size() - wb, 4 * blocks);
      for (int k = 0; k < 4 * blocks; k++) begin
        exp_a = model_ptr + 28'(k * step);
        if (rb + k < rd_log.size()) checkOutput($sformatf("rnd%0d_addr%0d", i, k), rd_log[rb + k], exp_a);
        if (wb + k < wr_log.size()) checkOutput($sformatf("rnd%0d_data%0d", i, k), wr_log[wb + k], data_of(exp_a));
      end
      checkOutput($sformatf("rnd%0d_irq", i), irq_cnt - ib, irq_enable ? blocks : 0);
      model_ptr = model_ptr + 28'(4 * blocks * step);
    end

    checkOutput("rd_wr_exclusive", excl_err, 0);
    checkOutput("irq_one_cycle",   irq_wide, 0);
    checkOutput("wr_addr_be",      attr_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
